// File: rtl/instr_seq_if.sv
// Fetch-side and decode-side bus of the instruction sequencer.
// The sequencer uses the master view; the ROM/consumer/flush environment uses the slave view.
interface instr_seq_if #(
  parameter int ADDR_W = 16
);
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_req;
  logic              fetch_ack;
  logic [15:0]       fetch_data;
  logic              flush;
  logic [ADDR_W-1:0] flush_addr;
  logic              dec_valid;
  logic              dec_ready;
  logic [15:0]       dec_instr;
  logic [15:0]       dec_src_ext;
  logic [15:0]       dec_dst_ext;
  logic [1:0]        dec_fmt;
  logic [1:0]        dec_ext_cnt;
  logic [ADDR_W-1:0] dec_pc;

  modport master (
    output fetch_addr, fetch_req, dec_valid, dec_instr, dec_src_ext, dec_dst_ext,
           dec_fmt, dec_ext_cnt, dec_pc,
    input  fetch_ack, fetch_data, flush, flush_addr, dec_ready
  );

  modport slave (
    input  fetch_addr, fetch_req, dec_valid, dec_instr, dec_src_ext, dec_dst_ext,
           dec_fmt, dec_ext_cnt, dec_pc,
    output fetch_ack, fetch_data, flush, flush_addr, dec_ready
  );
endinterface

// File: rtl/instr_seq.sv
// MSP430 instruction sequencer: fetches opcode + extension words, emits whole instructions; dec_valid 1 cycle after last word.
// Backpressure: fetch_req drops while the output buffer is full and not being popped; flush redirects fetch and empties everything.
module instr_seq #(
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(16'hC000),
  parameter int                OUT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  instr_seq_if.master bus
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = $clog2(OUT_DEPTH + 1);

  typedef enum logic [1:0] {S_OP, S_SRC, S_DST} state_t;

  typedef struct packed {
    logic [15:0]       instr;
    logic [15:0]       src_ext;
    logic [15:0]       dst_ext;
    logic [1:0]        fmt;
    logic [1:0]        ext_cnt;
    logic [ADDR_W-1:0] pc;
  } dec_t;

  state_t            state, state_nxt;
  logic              run;
  logic [ADDR_W-1:0] addr;
  dec_t              part;
  logic              need_dst;
  dec_t              buf_mem [OUT_DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count;

  logic              full, dec_vld, accept, push, pop;
  logic [1:0]        op_fmt, op_as;
  logic [3:0]        op_rs;
  logic              op_src, op_dst;
  dec_t              entry, head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full          = (count == CW'(OUT_DEPTH));
  assign dec_vld       = (count != '0);
  assign bus.fetch_req = run && (!full || bus.dec_ready);
  assign accept        = bus.fetch_req && bus.fetch_ack;
  assign pop           = dec_vld && bus.dec_ready && !bus.flush;
  assign bus.fetch_addr = addr;

  // Rs/Ad fields sit in different places for single-operand instructions
  always_comb begin
    if (bus.fetch_data[15:13] == 3'b001)         op_fmt = 2'd3;
    else if (bus.fetch_data[15:10] == 6'b000100) op_fmt = 2'd2;
    else if (bus.fetch_data[15:12] >= 4'd4)      op_fmt = 2'd1;
    else                                         op_fmt = 2'd0;
    op_rs  = (op_fmt == 2'd2) ? bus.fetch_data[3:0] : bus.fetch_data[11:8];
    op_as  = bus.fetch_data[5:4];
    op_src = ((op_fmt == 2'd1) || (op_fmt == 2'd2)) &&
             (((op_as == 2'b01) && (op_rs != 4'd3)) || ((op_as == 2'b11) && (op_rs == 4'd0)));
    op_dst = (op_fmt == 2'd1) && bus.fetch_data[7];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_OP;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    entry     = part;
    case (state)
      S_OP: begin
        entry.instr   = bus.fetch_data;
        entry.src_ext = '0;
        entry.dst_ext = '0;
        entry.fmt     = op_fmt;
        entry.ext_cnt = 2'd0;
        entry.pc      = addr;
        if (accept) begin
          if (op_src)      state_nxt = S_SRC;
          else if (op_dst) state_nxt = S_DST;
          else             push      = 1'b1;
        end
      end
      S_SRC: begin
        entry.src_ext = bus.fetch_data;
        entry.ext_cnt = 2'd1;
        if (accept) begin
          if (need_dst) state_nxt = S_DST;
          else begin
            push      = 1'b1;
            state_nxt = S_OP;
          end
        end
      end
      S_DST: begin
        entry.dst_ext = bus.fetch_data;
        entry.ext_cnt = part.ext_cnt + 2'd1;
        if (accept) begin
          push      = 1'b1;
          state_nxt = S_OP;
        end
      end
      default: state_nxt = S_OP;
    endcase
    if (bus.flush) begin
      state_nxt = S_OP;
      push      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= 1'b0;
      addr     <= RESET_VEC;
      part     <= '0;
      need_dst <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      run <= 1'b1;
      if (bus.flush) begin
        addr   <= bus.flush_addr & ~ADDR_W'(1);
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (accept) begin
          addr <= addr + ADDR_W'(2);
          part <= entry;
          if (state == S_OP) need_dst <= op_dst;
        end
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr] <= entry;
  end

  assign head            = dec_vld ? buf_mem[rd_ptr] : '0;
  assign bus.dec_valid   = dec_vld;
  assign bus.dec_instr   = head.instr;
  assign bus.dec_src_ext = head.src_ext;
  assign bus.dec_dst_ext = head.dst_ext;
  assign bus.dec_fmt     = head.fmt;
  assign bus.dec_ext_cnt = head.ext_cnt;
  assign bus.dec_pc      = head.pc;

endmodule

// File: doc/instr_seq.md
INSTR_SEQ -- requirements
Module: instr_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, meaning fetch address width (20 for MSP430X).
REQ-002 SHALL have parameter RESET_VEC, default 16'hC000 zero-extended to ADDR_W, meaning first fetch address after reset.
REQ-003 SHALL have parameter OUT_DEPTH, default 2, meaning decoded-instruction output buffer entries (1..4).
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 fetch_addr  out  ADDR_W  word address presented to ROM.
REQ-007 fetch_req  out  1  fetch request; word accepted on a cycle with fetch_req && fetch_ack.
REQ-008 fetch_ack  in  1  ROM returns fetch_data for fetch_addr in the same cycle.
REQ-009 fetch_data  in  16  instruction or extension word.
REQ-010 flush  in  1  discard in-flight and buffered work; redirect fetch.
REQ-011 flush_addr  in  ADDR_W  new fetch address on flush.
REQ-012 dec_valid  out  1  head of output buffer holds a complete instruction.
REQ-013 dec_ready  in  1  consumer accepts head when dec_valid && dec_ready.
REQ-014 dec_instr  out  16  opcode word; dec_src_ext, dec_dst_ext  out  16 each  extension words (0 if absent).
REQ-015 dec_fmt  out  2  1=Format I, 2=Format II, 3=jump, 0=illegal; dec_ext_cnt  out  2  extension words consumed (0..2).
REQ-016 dec_pc  out  ADDR_W  address of opcode word.

Function
REQ-017 SHALL implement FSM states OP, SRC, DST; reset state OP.
REQ-018 In OP, an accepted word SHALL be classified: bits[15:13]=001 -> jump; bits[15:10]=000100 -> Format II; bits[15:12]>=4 -> Format I; else illegal.
REQ-019 Source extension SHALL be needed for Format I/II when As=01 and Rs!=3, or As=11 and Rs=0; Rs=3 (any As) and Rs=2 with As=1x SHALL need none (constant generator).
REQ-020 Destination extension SHALL be needed for Format I when Ad=1; never for Format II, jump, or illegal.
REQ-021 OP -> SRC if source ext needed, else -> DST if destination ext needed, else instruction complete; SRC -> DST if destination ext needed, else complete; DST -> complete.
REQ-022 On completion, the instruction SHALL be written to the output buffer in the same edge the last word is accepted, and the FSM SHALL return to OP.
REQ-023 fetch_addr SHALL increment by 2 (mod 2^ADDR_W, wrapping) on each accepted word.
REQ-024 fetch_req SHALL be deasserted when accepting the next word could complete an instruction into a full buffer; partial extension fetches SHALL proceed only while one free entry exists.
REQ-025 Buffer SHALL be FIFO order; simultaneous write and pop when full SHALL be allowed.
REQ-026 dec_valid SHALL assert the cycle after the completing word is accepted (latency 1 from last word).
REQ-027 flush SHALL take priority: next edge empties buffer, FSM -> OP, fetch_addr <= flush_addr; words acked in the flush cycle SHALL be discarded.
REQ-028 A flush_addr with bit 0 set SHALL be loaded with bit 0 cleared.
REQ-029 Illegal words SHALL be emitted with dec_fmt=0, dec_ext_cnt=0.
REQ-030 dec_* outputs other than dec_valid SHALL be 0 when dec_valid=0.

Reset
REQ-031 While rst=1: FSM=OP, buffer empty, dec_valid=0, all dec_* = 0, fetch_addr=RESET_VEC, fetch_req=0.
REQ-032 fetch_req SHALL assert on the first rising edge after rst deasserts; rst asserted mid-instruction SHALL discard partial state immediately.

Verification
REQ-033 Words 0x4506, ack every cycle -> one output: fmt=1, ext_cnt=0, dec_pc=0xC000; next fetch_addr 0xC002.
REQ-034 0x4036, 0x1234 -> fmt=1, src_ext=0x1234, ext_cnt=1; 0x4316 -> ext_cnt=0 (constant generator).
REQ-035 0x4596, 0x0002, 0x0004 -> src_ext=0x0002, dst_ext=0x0004, ext_cnt=2, dec_pc of opcode word.
REQ-036 dec_ready=0 with OUT_DEPTH=2, stream 0x3C00 repeated -> two entries buffered, fetch_req drops, no words lost; release -> FIFO order preserved.
REQ-037 flush with flush_addr=0xF001 after accepting 0x4596 only -> buffer empty, FSM=OP, fetch_addr=0xF000, partial instruction never emitted.
REQ-038 fetch_addr=0xFFFE, accept word -> fetch_addr wraps to 0x0000.
